// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Data-memory responder for the register file's load/store port. Stores are
//   posted into a small in-order store buffer and drained one per cycle into a
//   single-port 2^AW x 8 array whenever the array is not being read. Loads are
//   ordered behind every store that was buffered when they were accepted.
//
//   Optional feature: define DATA_MEM_BYPASS_EN to let an idle-state load that
//   hits a buffered address return the youngest matching store data on the
//   acceptance edge, without an array read.
//
// Ports
//   clk         clock, all state on posedge
//   rst_n       asynchronous active-low reset
//   stor_req    store request (addr, stor_data)
//   load_req    load request (addr); a simultaneous store wins
//   addr        shared request address
//   stor_data   store data
//   stor_ready  buffer has a free entry
//   load_ready  controller idle, a load can be accepted
//   load_data   load result, held between responses
//   load_valid  one-cycle pulse marking a load response
//   sb_count    occupied store-buffer entries
//
// state   | meaning
// S_IDLE  | no load in flight; buffer drains freely
// S_DRAIN | draining the stores older than the pending load
// S_RD    | array read in progress, no draining

module data_mem_ctrl #(
  parameter int AW       = 8,
  parameter int SB_DEPTH = 4,
  parameter int READ_LAT = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            stor_req,
  input  logic                            load_req,
  input  logic [AW-1:0]                   addr,
  input  logic [7:0]                      stor_data,
  output logic                            stor_ready,
  output logic                            load_ready,
  output logic [7:0]                      load_data,
  output logic                            load_valid,
  output logic [$clog2(SB_DEPTH+1)-1:0]   sb_count
);

  localparam int CW = $clog2(SB_DEPTH + 1);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int RW = $clog2(READ_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_RD} state_t;

  state_t        state;
  state_t        state_nxt;

  // Entry 0 is always the oldest buffered store.
  logic [AW-1:0] sb_addr [SB_DEPTH];
  logic [7:0]    sb_data [SB_DEPTH];
  logic [7:0]    mem     [2**AW];

  logic [CW-1:0] drain_left;
  logic [RW-1:0] rd_cnt;
  logic [AW-1:0] addr_q;

  logic          enq;
  logic          drain;
  logic          load_acc;
  logic          byp_hit;
  logic [PW-1:0] wr_idx;

  assign enq      = stor_req && stor_ready;
  assign load_acc = load_req && load_ready && !stor_req;
  assign drain    = ((state == S_IDLE) || (state == S_DRAIN)) && (sb_count != '0);
  // On a drain edge the queue shifts down, so the tail slot moves down by one.
  assign wr_idx   = drain ? PW'(sb_count - CW'(1)) : PW'(sb_count);

`ifdef DATA_MEM_BYPASS_EN
  logic [7:0] byp_data;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if ((CW'(i) < sb_count) && (sb_addr[i] == addr)) begin
        byp_hit  = 1'b1;
        byp_data = sb_data[i];
      end
    end
  end
`else
  assign byp_hit = 1'b0;
`endif

  // Store buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_count <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr[i] <= '0;
        sb_data[i] <= '0;
      end
    end else begin
      if (drain) begin
        for (int i = 0; i < SB_DEPTH - 1; i++) begin
          sb_addr[i] <= sb_addr[i+1];
          sb_data[i] <= sb_data[i+1];
        end
      end
      if (enq) begin
        sb_addr[wr_idx] <= addr;
        sb_data[wr_idx] <= stor_data;
      end
      if (enq && !drain) begin
        sb_count <= sb_count + CW'(1);
      end else if (!enq && drain) begin
        sb_count <= sb_count - CW'(1);
      end
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (drain) begin
      mem[sb_addr[0]] <= sb_data[0];
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        // With zero or one older store, that store drains on the accept edge.
        if (load_acc && !byp_hit) begin
          state_nxt = (sb_count > CW'(1)) ? S_DRAIN : S_RD;
        end
      end
      S_DRAIN: begin
        if (drain_left == CW'(1)) begin
          state_nxt = S_RD;
        end
      end
      S_RD: begin
        if (rd_cnt == RW'(1)) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    stor_ready = (sb_count < CW'(SB_DEPTH));
    load_ready = (state == S_IDLE);
  end

  // Load datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_left <= '0;
      rd_cnt     <= '0;
      addr_q     <= '0;
      load_data  <= 8'h00;
      load_valid <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_acc) begin
            addr_q <= addr;
            rd_cnt <= RW'(READ_LAT);
            if (sb_count > CW'(1)) begin
              drain_left <= sb_count - CW'(1);
            end
`ifdef DATA_MEM_BYPASS_EN
            if (byp_hit) begin
              load_data  <= byp_data;
              load_valid <= 1'b1;
            end
`endif
          end
        end
        S_DRAIN: begin
          drain_left <= drain_left - CW'(1);
        end
        S_RD: begin
          rd_cnt <= rd_cnt - RW'(1);
          if (rd_cnt == RW'(1)) begin
            load_data  <= mem[addr_q];
            load_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl. The array read latency is
// stretched to 4 so that a single in-flight load can back up a full buffer;
// every expected latency below is written in terms of RL.
module tb_data_mem_ctrl;

  localparam int RL = 4;

  logic       clk;
  logic       rst_n;
  logic       stor_req;
  logic       load_req;
  logic [7:0] addr;
  logic [7:0] stor_data;
  logic       stor_ready;
  logic       load_ready;
  logic [7:0] load_data;
  logic       load_valid;
  logic [2:0] sb_count;

  int checks;
  int failures;

  data_mem_ctrl #(.AW(8), .SB_DEPTH(4), .READ_LAT(RL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stor_req   (stor_req),
    .load_req   (load_req),
    .addr       (addr),
    .stor_data  (stor_data),
    .stor_ready (stor_ready),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_valid (load_valid),
    .sb_count   (sb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (load_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", load_valid); end
    checks++; if (load_data !== 8'h00) begin failures++; $display("FAIL rst_data: got %h want 00", load_data); end
    checks++; if (sb_count !== 3'd0) begin failures++; $display("FAIL rst_count: got %0d want 0", sb_count); end
    checks++; if (stor_ready !== 1'b1) begin failures++; $display("FAIL rst_stor_ready: got %b want 1", stor_ready); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL rst_load_ready: got %b want 1", load_ready); end
    @(posedge clk); #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_store_load();
    stor_req = 1'b1; addr = 8'h10; stor_data = 8'hA5;
    step();
    stor_req = 1'b0;
    checks++; if (sb_count !== 3'd1) begin failures++; $display("FAIL sl_count1: got %0d want 1", sb_count); end
    step(); step(); step();
    checks++; if (sb_count !== 3'd0) begin failures++; $display("FAIL sl_count0: got %0d want 0", sb_count); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL sl_load_ready: got %b want 1", load_ready); end
    load_req = 1'b1; addr = 8'h10;
    step();
    load_req = 1'b0;
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL sl_busy: got %b want 0", load_ready); end
    checks++; if (load_valid !== 1'b0) begin failures++; $display("FAIL sl_early0: got %b want 0", load_valid); end
    for (int c = 1; c < RL; c++) begin
      step();
      checks++; if (load_valid !== 1'b0) begin failures++; $display("FAIL sl_early: cycle %0d got %b want 0", c, load_valid); end
    end
    step();
    checks++; if (load_valid !== 1'b1) begin failures++; $display("FAIL sl_valid: got %b want 1", load_valid); end
    checks++; if (load_data !== 8'hA5) begin failures++; $display("FAIL sl_data: got %h want a5", load_data); end
    step();
    checks++; if (load_valid !== 1'b0) begin failures++; $display("FAIL sl_pulse: got %b want 0", load_valid); end
    checks++; if (load_data !== 8'hA5) begin failures++; $display("FAIL sl_hold: got %h want a5", load_data); end
  endtask

  task automatic test_priority();
    stor_req = 1'b1; load_req = 1'b1; addr = 8'h40; stor_data = 8'h77;
    step();
    stor_req = 1'b0;
    checks++; if (sb_count !== 3'd1) begin failures++; $display("FAIL pri_count: got %0d want 1", sb_count); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL pri_not_taken: got %b want 1", load_ready); end
    step();
    load_req = 1'b0;
    checks++; if (sb_count !== 3'd0) begin failures++; $display("FAIL pri_drain: got %0d want 0", sb_count); end
`ifdef DATA_MEM_BYPASS_EN
    checks++; if (load_valid !== 1'b1) begin failures++; $display("FAIL pri_byp_valid: got %b want 1", load_valid); end
    checks++; if (load_data !== 8'h77) begin failures++; $display("FAIL pri_byp_data: got %h want 77", load_data); end
`else
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL pri_busy: got %b want 0", load_ready); end
    for (int c = 1; c < RL; c++) begin
      step();
      checks++; if (load_valid !== 1'b0) begin failures++; $display("FAIL pri_early: cycle %0d got %b want 0", c, load_valid); end
    end
    step();
    checks++; if (load_valid !== 1'b1) begin failures++; $display("FAIL pri_valid: got %b want 1", load_valid); end
    checks++; if (load_data !== 8'h77) begin failures++; $display("FAIL pri_data: got %h want 77", load_data); end
`endif
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] la [2];
    logic [7:0] ld [2];
    la[0] = 8'h64; ld[0] = 8'h05;
    la[1] = 8'h62; ld[1] = 8'h03;
    stor_req = 1'b1; addr = 8'h00; stor_data = 8'h3C;
    step();
    stor_req = 1'b0;
    step();
    load_req = 1'b1; addr = 8'h00;
    step();
    load_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      stor_req = 1'b1; addr = 8'h60 + 8'(k); stor_data = 8'(k + 1);
      step();
      checks++; if (sb_count !== 3'(k + 1)) begin failures++; $display("FAIL b2b_fill: store %0d got %0d want %0d", k, sb_count, k + 1); end
    end
    checks++; if (load_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid: got %b want 1", load_valid); end
    checks++; if (load_data !== 8'h3C) begin failures++; $display("FAIL b2b_data: got %h want 3c", load_data); end
    checks++; if (stor_ready !== 1'b0) begin failures++; $display("FAIL b2b_full: got %b want 0", stor_ready); end
    addr = 8'h64; stor_data = 8'h05;
    step();
    checks++; if (sb_count !== 3'd3) begin failures++; $display("FAIL b2b_held: got %0d want 3", sb_count); end
    checks++; if (stor_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready: got %b want 1", stor_ready); end
    step();
    stor_req = 1'b0;
    checks++; if (sb_count !== 3'd3) begin failures++; $display("FAIL b2b_enq_drain: got %0d want 3", sb_count); end
    for (int e = 2; e >= 0; e--) begin
      step();
      checks++; if (sb_count !== 3'(e)) begin failures++; $display("FAIL b2b_drain: got %0d want %0d", sb_count, e); end
    end
    for (int t = 0; t < 2; t++) begin
      load_req = 1'b1; addr = la[t];
      step();
      load_req = 1'b0;
      for (int c = 1; c < RL; c++) step();
      step();
      checks++; if (load_valid !== 1'b1) begin failures++; $display("FAIL b2b_rd_valid: addr %h got %b want 1", la[t], load_valid); end
      checks++; if (load_data !== ld[t]) begin failures++; $display("FAIL b2b_rd_data: addr %h got %h want %h", la[t], load_data, ld[t]); end
    end
    step();
  endtask

  task automatic test_bypass();
    load_req = 1'b1; addr = 8'h71;
    step();
    load_req = 1'b0;
    stor_req = 1'b1; addr = 8'h30; stor_data = 8'h11;
    step();
    stor_data = 8'h22;
    step();
    stor_req = 1'b0;
    for (int c = 2; c < RL; c++) step();
    checks++; if (load_valid !== 1'b1) begin failures++; $display("FAIL byp_first_valid: got %b want 1", load_valid); end
    checks++; if (sb_count !== 3'd2) begin failures++; $display("FAIL byp_queued: got %0d want 2", sb_count); end
    load_req = 1'b1; addr = 8'h30;
    step();
    load_req = 1'b0;
    checks++; if (sb_count !== 3'd1) begin failures++; $display("FAIL byp_count: got %0d want 1", sb_count); end
`ifdef DATA_MEM_BYPASS_EN
    checks++; if (load_valid !== 1'b1) begin failures++; $display("FAIL byp_valid: got %b want 1", load_valid); end
    checks++; if (load_data !== 8'h22) begin failures++; $display("FAIL byp_data: got %h want 22", load_data); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL byp_idle: got %b want 1", load_ready); end
`else
    checks++; if (load_valid !== 1'b0) begin failures++; $display("FAIL byp_early0: got %b want 0", load_valid); end
    for (int c = 1; c <= RL; c++) begin
      step();
      checks++; if (load_valid !== 1'b0) begin failures++; $display("FAIL byp_early: cycle %0d got %b want 0", c, load_valid); end
    end
    step();
    checks++; if (load_valid !== 1'b1) begin failures++; $display("FAIL byp_valid: got %b want 1", load_valid); end
    checks++; if (load_data !== 8'h22) begin failures++; $display("FAIL byp_data: got %h want 22", load_data); end
`endif
    step(); step();
    checks++; if (sb_count !== 3'd0) begin failures++; $display("FAIL byp_empty: got %0d want 0", sb_count); end
  endtask

  task automatic test_reset_mid_rd();
    int seen;
    load_req = 1'b1; addr = 8'h10;
    step();
    load_req = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (load_valid !== 1'b0) begin failures++; $display("FAIL mrst_valid: got %b want 0", load_valid); end
    checks++; if (load_data !== 8'h00) begin failures++; $display("FAIL mrst_data: got %h want 00", load_data); end
    checks++; if (sb_count !== 3'd0) begin failures++; $display("FAIL mrst_count: got %0d want 0", sb_count); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL mrst_load_ready: got %b want 1", load_ready); end
    checks++; if (stor_ready !== 1'b1) begin failures++; $display("FAIL mrst_stor_ready: got %b want 1", stor_ready); end
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < RL + 2; c++) begin
      step();
      if (load_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL mrst_dropped: got %0d pulses want 0", seen); end
  endtask

  task automatic test_reset_drain();
    stor_req = 1'b1; addr = 8'h50; stor_data = 8'h00;
    step();
    stor_req = 1'b0;
    step();
    load_req = 1'b1; addr = 8'h70;
    step();
    load_req = 1'b0;
    stor_req = 1'b1; addr = 8'h51; stor_data = 8'hAA;
    step();
    addr = 8'h52; stor_data = 8'hBB;
    step();
    addr = 8'h50; stor_data = 8'h99;
    step();
    stor_req = 1'b0;
    for (int c = 3; c < RL; c++) step();
    checks++; if (sb_count !== 3'd3) begin failures++; $display("FAIL drst_queued: got %0d want 3", sb_count); end
    load_req = 1'b1; addr = 8'h70;
    step();
    load_req = 1'b0;
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL drst_in_drain: got %b want 0", load_ready); end
    checks++; if (sb_count !== 3'd2) begin failures++; $display("FAIL drst_count: got %0d want 2", sb_count); end
    rst_n = 1'b0;
    #1;
    checks++; if (sb_count !== 3'd0) begin failures++; $display("FAIL drst_lost: got %0d want 0", sb_count); end
    @(posedge clk); #1 rst_n = 1'b1;
    step();
    load_req = 1'b1; addr = 8'h50;
    step();
    load_req = 1'b0;
    for (int c = 1; c < RL; c++) step();
    step();
    checks++; if (load_valid !== 1'b1) begin failures++; $display("FAIL drst_valid: got %b want 1", load_valid); end
    checks++; if (load_data !== 8'h00) begin failures++; $display("FAIL drst_data: got %h want 00", load_data); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    stor_req  = 1'b0;
    load_req  = 1'b0;
    addr      = 8'h00;
    stor_data = 8'h00;
    test_reset();
    test_store_load();
    test_priority();
    test_back_to_back();
    test_bypass();
    test_reset_mid_rd();
    test_reset_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
